// File: rtl/nn_inference_div_seq_27s_16s_16.sv
// Sequential signed divider: radix-2 restoring division on magnitudes plus a sign fixup.
// Optional build macro NN_INFERENCE_DIV_SAT_EN saturates dout on overflow (default: wrap).
`timescale 1ns/1ps
module nn_inference_div_seq_27s_16s_16 #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 27,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [dout_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  div_by_zero
);

  localparam int W0 = din0_WIDTH;
  localparam int W1 = din1_WIDTH;
  localparam int WO = dout_WIDTH;
  localparam int CW = $clog2(W0 + 1);

  localparam logic [WO-1:0] SAT_MAX = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0] SAT_MIN = {1'b1, {(WO-1){1'b0}}};
  localparam logic [W0-1:0] POS_LIM = W0'(SAT_MAX);
  localparam logic [W0-1:0] NEG_LIM = W0'(SAT_MIN);

  // ID is an instance tag only; this block just keeps it referenced.
  if (ID < 0) begin : g_id_tag
  end

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          sign0;
  logic          sign1;
  logic          zero;
  // dvd shifts dividend bits out of the top while quotient bits enter at the bottom
  logic [W0-1:0] dvd;
  logic [W1-1:0] dvs;
  logic [W1-1:0] prem;

  logic [W0-1:0] din0_mag;
  logic [W1-1:0] din1_mag;
  logic [W1:0]   shifted;
  logic          trial_ge;
  logic [W1-1:0] diff;
  logic [W1-1:0] prem_next;

  logic          neg_q;
  logic [WO-1:0] q_lo;
  logic [WO-1:0] q_wrap;
  logic [WO-1:0] d0_lo;
  logic [W1-1:0] r_signed;
  logic          ovf_calc;
  logic [WO-1:0] dout_fix;
  logic [WO-1:0] rem_fix;
  logic          ovf_fix;

  always_comb begin
    din0_mag = din0[W0-1] ? (~din0 + 1'b1) : din0;
    din1_mag = din1[W1-1] ? (~din1 + 1'b1) : din1;

    // partial remainder stays below the divisor magnitude, so the low W1 bits
    // of the modular difference are exact whenever the trial succeeds
    shifted   = {prem, dvd[W0-1]};
    trial_ge  = shifted >= {1'b0, dvs};
    diff      = shifted[W1-1:0] - dvs;
    prem_next = trial_ge ? diff : shifted[W1-1:0];
  end

  always_comb begin
    neg_q    = sign0 ^ sign1;
    q_lo     = dvd[WO-1:0];
    q_wrap   = neg_q ? (~q_lo + 1'b1) : q_lo;
    d0_lo    = sign0 ? (~q_lo + 1'b1) : q_lo;
    r_signed = sign0 ? (~prem + 1'b1) : prem;
    ovf_calc = neg_q ? (dvd > NEG_LIM) : (dvd > POS_LIM);

    dout_fix = q_wrap;
    rem_fix  = r_signed[WO-1:0];
    ovf_fix  = ovf_calc;
    if (zero) begin
      // dvd still holds |din0| here, so d0_lo recovers the raw low bits of din0
      dout_fix = sign0 ? SAT_MIN : SAT_MAX;
      rem_fix  = d0_lo;
      ovf_fix  = 1'b1;
    end else if (ovf_calc) begin
`ifdef NN_INFERENCE_DIV_SAT_EN
      dout_fix = neg_q ? SAT_MIN : SAT_MAX;
`else
      dout_fix = q_wrap;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      sign0       <= 1'b0;
      sign1       <= 1'b0;
      zero        <= 1'b0;
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      ready       <= 1'b1;
      done        <= 1'b0;
      dout        <= '0;
      rem         <= '0;
      ovf         <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (ce) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign0 <= din0[W0-1];
            sign1 <= din1[W1-1];
            dvd   <= din0_mag;
            dvs   <= din1_mag;
            prem  <= '0;
            count <= CW'(W0);
            zero  <= (din1 == '0);
            ready <= 1'b0;
            state <= (din1 == '0) ? FIXUP : CALC;
          end
        end
        CALC: begin
          prem  <= prem_next;
          dvd   <= {dvd[W0-2:0], trial_ge};
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            state <= FIXUP;
          end
        end
        FIXUP: begin
          dout        <= dout_fix;
          rem         <= rem_fix;
          ovf         <= ovf_fix;
          div_by_zero <= zero;
          done        <= 1'b1;
          ready       <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_inference_div_seq_27s_16s_16.sv
// Scoreboard bench for the sequential signed divider: stimulus pushes expected results,
// a negedge monitor pops and compares them whenever done pulses.
`timescale 1ns/1ps
module tb_nn_inference_div_seq_27s_16s_16;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        start;
  logic [26:0] din0;
  logic [15:0] din1;
  logic        ready;
  logic        done;
  logic [15:0] dout;
  logic [15:0] rem;
  logic        ovf;
  logic        div_by_zero;

  always #5 clk = ~clk;

  nn_inference_div_seq_27s_16s_16 #(
    .ID(1), .din0_WIDTH(27), .din1_WIDTH(16), .dout_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start), .din0(din0), .din1(din1),
    .ready(ready), .done(done), .dout(dout), .rem(rem), .ovf(ovf),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    longint      a;
    longint      b;
    logic [15:0] dout;
    logic [15:0] rem;
    logic        ovf;
    logic        dbz;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   active_cnt = 0;
  logic edge_active = 1'b0;

  always @(posedge clk) begin
    edge_active <= ce & ~reset;
    if (ce) active_cnt <= active_cnt + 1;
  end

  // Reference: C-style truncating division with plain integer arithmetic.
  function automatic exp_t model(input longint a, input longint b, input int due);
    exp_t        e;
    longint      q;
    longint      r;
    logic [63:0] bits;
    e.a = a; e.b = b; e.due = due;
    if (b == 0) begin
      e.dbz  = 1'b1;
      e.ovf  = 1'b1;
      e.dout = (a >= 0) ? 16'h7fff : 16'h8000;
      bits   = a;
      e.rem  = bits[15:0];
    end else begin
      q     = a / b;
      r     = a % b;
      e.dbz = 1'b0;
      e.ovf = (q > 32767) || (q < -32768);
      bits  = q;
      e.dout = bits[15:0];
`ifdef NN_INFERENCE_DIV_SAT_EN
      if (e.ovf) e.dout = (q > 0) ? 16'h7fff : 16'h8000;
`endif
      bits  = r;
      e.rem = bits[15:0];
    end
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && edge_active && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1, expected no done (no pending start)");
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn %0d / %0d -> dout=%0d rem=%0d ovf=%0b dbz=%0b", e.a, e.b,
                 $signed(dout), $signed(rem), ovf, div_by_zero);
        check("dout", dout, e.dout);
        check("rem", rem, e.rem);
        check("ovf", ovf, e.ovf);
        check("div_by_zero", div_by_zero, e.dbz);
        check("latency", active_cnt, e.due);
      end
    end
  end

  // Called at posedge+1; waits for ready, then presents one start for one edge.
  task automatic issue(input longint a, input longint b);
    int guard = 0;
    while (!ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=0, expected ready=1 within 100 cycles");
      return;
    end
    ce    = 1'b1;
    start = 1'b1;
    din0  = 27'(a);
    din1  = 16'(b);
    sb.push_back(model(a, b, active_cnt + 1 + ((b == 0) ? 1 : 28)));
    @(posedge clk); #1;
    start = 1'b0;
    din0  = 27'($urandom);
    din1  = 16'($urandom);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_rem"}, rem, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_dbz"}, div_by_zero, 0);
  endtask

  longint dir_a[8] = '{1000, -1000, 1000, -1000, 67108863, -67108864, 500, -500};
  longint dir_b[8] = '{7, 7, -7, -7, 1, -1, 0, 0};

  initial begin
    reset = 1'b1; ce = 1'b1; start = 1'b0; din0 = '0; din1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) issue(dir_a[i], dir_b[i]);
    wait_idle();

    // stall for five cycles mid-calculation
    issue(1000, 7);
    repeat (5) begin @(posedge clk); #1; end
    ce = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    ce = 1'b1;
    wait_idle();

    // start while busy is dropped; start on the done cycle is accepted
    issue(1000, 7);
    repeat (3) begin @(posedge clk); #1; end
    check("busy_ready", ready, 0);
    start = 1'b1; din0 = 27'd9; din1 = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int g = 0; g < 60 && !ready; g++) begin @(posedge clk); #1; end
    check("b2b_done_cycle", done, 1);
    issue(9, 3);
    wait_idle();

    // asynchronous reset in the middle of a calculation
    issue(1000, 7);
    repeat (9) begin @(posedge clk); #1; end
    #1 reset = 1'b1;
    #1;
    check_reset_values("midreset");
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (35) begin @(posedge clk); #1; end
    issue(1000, 7);
    wait_idle();

    // randomized operands with random ce stalls
    for (int i = 0; i < 40; i++) begin
      logic [26:0] ra;
      logic [15:0] rb;
      longint a;
      longint b;
      ra = 27'($urandom);
      rb = 16'($urandom);
      a  = longint'($signed(ra));
      b  = longint'($signed(rb));
      case ($urandom_range(0, 3))
        0: a = longint'($urandom_range(0, 2097152)) - 1048576;
        1: a = -67108864;
        default: ;
      endcase
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = -32768;
        2: b = longint'($urandom_range(1, 200)) - 100;
        default: ;
      endcase
      issue(a, b);
      repeat ($urandom_range(0, 4)) begin
        @(posedge clk); #1;
        ce = 1'($urandom_range(0, 1));
      end
      ce = 1'b1;
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
